// File: rtl/wb_gain_corrector_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_gain_corrector_mc                                                       |
// | Per-channel AXI4-Stream white-balance gain with round-half-up, saturation, |
// | double-buffered gains applied at start of frame or immediately.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module wb_gain_corrector_mc #(
   parameter int CHANNELS    = 3,
   parameter int COMP_WIDTH  = 10,
   parameter int FRACT_WIDTH = 10,
   parameter int INT_WIDTH   = 2,
   parameter int GAIN_WIDTH  = INT_WIDTH + FRACT_WIDTH,
   parameter int TDATA_WIDTH = 32,
   parameter int FRAME_SYNC  = 1
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     gain_wr_i,
   input  logic [1:0]               gain_sel_i,
   input  logic [GAIN_WIDTH-1:0]    gain_data_i,
   input  logic                     bypass_i,
   output logic                     pending_o,
   output logic [15:0]              frame_cnt_o,
   input  logic                     video_i_tvalid,
   output logic                     video_i_tready,
   input  logic [TDATA_WIDTH-1:0]   video_i_tdata,
   input  logic [TDATA_WIDTH/8-1:0] video_i_tstrb,
   input  logic [TDATA_WIDTH/8-1:0] video_i_tkeep,
   input  logic                     video_i_tlast,
   input  logic                     video_i_tuser,
   output logic                     video_o_tvalid,
   input  logic                     video_o_tready,
   output logic [TDATA_WIDTH-1:0]   video_o_tdata,
   output logic [TDATA_WIDTH/8-1:0] video_o_tstrb,
   output logic [TDATA_WIDTH/8-1:0] video_o_tkeep,
   output logic                     video_o_tlast,
   output logic                     video_o_tuser
);

   localparam int KEEP_WIDTH = TDATA_WIDTH / 8;
   localparam int PROD_WIDTH = COMP_WIDTH + GAIN_WIDTH;
   localparam int USED_WIDTH = CHANNELS * COMP_WIDTH;
   localparam logic [GAIN_WIDTH-1:0] GAIN_ONE   = GAIN_WIDTH'(1) << FRACT_WIDTH;
   localparam logic [PROD_WIDTH:0]   ROUND_HALF = (PROD_WIDTH+1)'(1) << (FRACT_WIDTH-1);
   localparam logic [PROD_WIDTH:0]   COMP_MAX   = (PROD_WIDTH+1)'((1 << COMP_WIDTH) - 1);

   logic en, accept, sof, wr_ok;
   logic [GAIN_WIDTH-1:0] shadow_gain [CHANNELS];
   logic [GAIN_WIDTH-1:0] active_gain [CHANNELS];
   logic [GAIN_WIDTH-1:0] beat_gain   [CHANNELS];
   logic shadow_bypass, active_bypass, beat_bypass, pending;

   assign en             = !video_o_tvalid || video_o_tready;
   assign video_i_tready = en;
   assign accept         = video_i_tvalid && en;
   assign sof            = accept && video_i_tuser;
   assign wr_ok          = gain_wr_i && ({30'd0, gain_sel_i} < 32'(CHANNELS));
   assign pending_o      = pending;

   // An SOF beat must already see the shadow set it is about to promote.
   always_comb begin
      beat_bypass = active_bypass;
      for (int c = 0; c < CHANNELS; c++) beat_gain[c] = active_gain[c];
      if (FRAME_SYNC != 0 && sof) begin
         beat_bypass = shadow_bypass;
         for (int c = 0; c < CHANNELS; c++) beat_gain[c] = shadow_gain[c];
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         for (int c = 0; c < CHANNELS; c++) begin
            shadow_gain[c] <= GAIN_ONE;
            active_gain[c] <= GAIN_ONE;
         end
         shadow_bypass <= 1'b0;
         active_bypass <= 1'b0;
         pending       <= 1'b0;
      end else begin
         if ((FRAME_SYNC != 0) ? sof : pending) begin
            for (int c = 0; c < CHANNELS; c++) active_gain[c] <= shadow_gain[c];
            active_bypass <= shadow_bypass;
         end
         if (wr_ok) begin
            for (int c = 0; c < CHANNELS; c++)
               if (gain_sel_i == 2'(c)) shadow_gain[c] <= gain_data_i;
            shadow_bypass <= bypass_i;
         end
         // A write coinciding with the SOF accept stays pending for the next frame.
         if (wr_ok)
            pending <= 1'b1;
         else if ((FRAME_SYNC != 0) ? sof : 1'b1)
            pending <= 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i)
         frame_cnt_o <= 16'd0;
      else if (sof)
         frame_cnt_o <= frame_cnt_o + 16'd1;
   end

   logic                  s1_valid, s1_last, s1_user, s1_bypass;
   logic [USED_WIDTH-1:0] s1_px;
   logic [KEEP_WIDTH-1:0] s1_keep, s1_strb;
   logic [GAIN_WIDTH-1:0] s1_gain [CHANNELS];

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         s1_valid  <= 1'b0;
         s1_last   <= 1'b0;
         s1_user   <= 1'b0;
         s1_bypass <= 1'b0;
         s1_px     <= '0;
         s1_keep   <= '0;
         s1_strb   <= '0;
         for (int c = 0; c < CHANNELS; c++) s1_gain[c] <= '0;
      end else if (en) begin
         s1_valid  <= video_i_tvalid;
         s1_last   <= video_i_tlast;
         s1_user   <= video_i_tuser;
         s1_bypass <= beat_bypass;
         s1_px     <= video_i_tdata[USED_WIDTH-1:0];
         s1_keep   <= video_i_tkeep;
         s1_strb   <= video_i_tstrb;
         for (int c = 0; c < CHANNELS; c++) s1_gain[c] <= beat_gain[c];
      end
   end

   logic [PROD_WIDTH-1:0] prod [CHANNELS];

   always_comb begin
      for (int c = 0; c < CHANNELS; c++)
         prod[c] = PROD_WIDTH'(s1_px[c*COMP_WIDTH +: COMP_WIDTH]) * PROD_WIDTH'(s1_gain[c]);
   end

   logic                  s2_valid, s2_last, s2_user, s2_bypass;
   logic [USED_WIDTH-1:0] s2_px;
   logic [KEEP_WIDTH-1:0] s2_keep, s2_strb;
   logic [PROD_WIDTH-1:0] s2_prod [CHANNELS];

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         s2_valid  <= 1'b0;
         s2_last   <= 1'b0;
         s2_user   <= 1'b0;
         s2_bypass <= 1'b0;
         s2_px     <= '0;
         s2_keep   <= '0;
         s2_strb   <= '0;
         for (int c = 0; c < CHANNELS; c++) s2_prod[c] <= '0;
      end else if (en) begin
         s2_valid  <= s1_valid;
         s2_last   <= s1_last;
         s2_user   <= s1_user;
         s2_bypass <= s1_bypass;
         s2_px     <= s1_px;
         s2_keep   <= s1_keep;
         s2_strb   <= s1_strb;
         for (int c = 0; c < CHANNELS; c++) s2_prod[c] <= prod[c];
      end
   end

   logic [TDATA_WIDTH-1:0] res_data;
   logic [PROD_WIDTH:0]    sum, rnd;

   always_comb begin
      res_data = '0;
      sum      = '0;
      rnd      = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         sum = {1'b0, s2_prod[c]} + ROUND_HALF;
         rnd = sum >> FRACT_WIDTH;
         if (s2_bypass)
            res_data[c*COMP_WIDTH +: COMP_WIDTH] = s2_px[c*COMP_WIDTH +: COMP_WIDTH];
         else if (rnd > COMP_MAX)
            res_data[c*COMP_WIDTH +: COMP_WIDTH] = {COMP_WIDTH{1'b1}};
         else
            res_data[c*COMP_WIDTH +: COMP_WIDTH] = rnd[COMP_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         video_o_tvalid <= 1'b0;
         video_o_tdata  <= '0;
         video_o_tstrb  <= '0;
         video_o_tkeep  <= '0;
         video_o_tlast  <= 1'b0;
         video_o_tuser  <= 1'b0;
      end else if (en) begin
         video_o_tvalid <= s2_valid;
         video_o_tdata  <= res_data;
         video_o_tstrb  <= s2_strb;
         video_o_tkeep  <= s2_keep;
         video_o_tlast  <= s2_last;
         video_o_tuser  <= s2_user;
      end
   end

   generate
      if (USED_WIDTH < TDATA_WIDTH) begin : g_pad_unused
         logic unused_pad;
         assign unused_pad = ^video_i_tdata[TDATA_WIDTH-1:USED_WIDTH];
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_wb_gain_corrector_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_wb_gain_corrector_mc                                                    |
// | Directed self-checking bench for the multi-channel white-balance stage.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_wb_gain_corrector_mc;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  keep;
      logic [3:0]  strb;
      logic        last;
      logic        user;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        gain_wr = 1'b0;
   logic [1:0]  gain_sel = 2'd0;
   logic [11:0] gain_data = 12'd0;
   logic        bypass = 1'b0;
   logic        pending;
   logic [15:0] frame_cnt;
   logic        vi_valid = 1'b0, vi_ready;
   logic [31:0] vi_data = 32'd0;
   logic [3:0]  vi_strb = 4'hF, vi_keep = 4'hF;
   logic        vi_last = 1'b0, vi_user = 1'b0;
   logic        vo_valid, vo_ready = 1'b1;
   logic [31:0] vo_data;
   logic [3:0]  vo_strb, vo_keep;
   logic        vo_last, vo_user;

   int n_checks = 0;
   int n_pass   = 0;
   beat_t out_q[$];
   beat_t mon_b;

   wb_gain_corrector_mc dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .gain_wr_i(gain_wr), .gain_sel_i(gain_sel), .gain_data_i(gain_data), .bypass_i(bypass),
      .pending_o(pending), .frame_cnt_o(frame_cnt),
      .video_i_tvalid(vi_valid), .video_i_tready(vi_ready), .video_i_tdata(vi_data),
      .video_i_tstrb(vi_strb), .video_i_tkeep(vi_keep), .video_i_tlast(vi_last), .video_i_tuser(vi_user),
      .video_o_tvalid(vo_valid), .video_o_tready(vo_ready), .video_o_tdata(vo_data),
      .video_o_tstrb(vo_strb), .video_o_tkeep(vo_keep), .video_o_tlast(vo_last), .video_o_tuser(vo_user)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n && vo_valid && vo_ready) begin
         mon_b.data = vo_data;
         mon_b.keep = vo_keep;
         mon_b.strb = vo_strb;
         mon_b.last = vo_last;
         mon_b.user = vo_user;
         out_q.push_back(mon_b);
      end
   end

   function automatic logic [31:0] pix(input logic [1:0] pad, input int c0, input int c1, input int c2);
      return {pad, 10'(c2), 10'(c1), 10'(c0)};
   endfunction

   function automatic logic [9:0] model(input int px, input int g);
      int r;
      r = (px * g + 512) >> 10;
      return (r > 1023) ? 10'd1023 : 10'(r);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      vi_valid = 1'b0;
      gain_wr  = 1'b0;
      vo_ready = 1'b1;
      repeat (3) tick();
      rst_n = 1'b1;
      out_q.delete();
   endtask

   task automatic write_gain(input logic [1:0] sel, input logic [11:0] g, input logic byp);
      gain_wr   = 1'b1;
      gain_sel  = sel;
      gain_data = g;
      bypass    = byp;
      tick();
      gain_wr = 1'b0;
      bypass  = 1'b0;
   endtask

   task automatic send(input logic [31:0] d, input logic u, input logic l,
                       input logic [3:0] k, input logic [3:0] s);
      bit acc;
      acc      = 0;
      vi_valid = 1'b1;
      vi_data  = d;
      vi_user  = u;
      vi_last  = l;
      vi_keep  = k;
      vi_strb  = s;
      for (int i = 0; i < 200 && !acc; i++) begin
         @(negedge clk);
         acc = vi_ready;
         tick();
      end
      vi_valid = 1'b0;
      if (!acc) begin
         n_checks++;
         $display("FAIL send_timeout: input beat %h not accepted within 200 cycles", d);
      end
   endtask

   task automatic recv(output beat_t b, output bit ok);
      b  = '0;
      ok = 0;
      for (int i = 0; i < 50; i++) begin
         if (out_q.size() > 0) begin
            b  = out_q.pop_front();
            ok = 1;
            return;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (vo_valid !== 1'b0) $display("FAIL reset_tvalid: got %b want 0", vo_valid); else n_pass++;
      n_checks++; if (vo_data !== 32'd0) $display("FAIL reset_tdata: got %h want 0", vo_data); else n_pass++;
      n_checks++; if ({vo_keep, vo_strb, vo_last, vo_user} !== 10'd0)
         $display("FAIL reset_sideband: got %h want 0", {vo_keep, vo_strb, vo_last, vo_user}); else n_pass++;
      n_checks++; if (pending !== 1'b0) $display("FAIL reset_pending: got %b want 0", pending); else n_pass++;
      n_checks++; if (frame_cnt !== 16'd0) $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); else n_pass++;
      n_checks++; if (vi_ready !== 1'b1) $display("FAIL reset_tready: got %b want 1", vi_ready); else n_pass++;
   endtask

   task automatic test_passthrough();
      beat_t b;
      bit    ok;
      send(pix(2'b11, 512, 100, 1023), 1'b1, 1'b0, 4'hF, 4'hF);
      tick();
      n_checks++; if (vo_valid !== 1'b0) $display("FAIL latency_early: tvalid got %b want 0", vo_valid); else n_pass++;
      tick();
      n_checks++; if (vo_valid !== 1'b1) $display("FAIL latency_3: tvalid got %b want 1", vo_valid); else n_pass++;
      n_checks++; if (vo_data !== pix(2'b00, 512, 100, 1023))
         $display("FAIL unity_data: got %h want %h", vo_data, pix(2'b00, 512, 100, 1023)); else n_pass++;
      recv(b, ok);
      n_checks++; if (!ok || b.user !== 1'b1 || b.keep !== 4'hF)
         $display("FAIL unity_sideband: ok %0d user %b keep %h want user 1 keep f", ok, b.user, b.keep); else n_pass++;
      n_checks++; if (frame_cnt !== 16'd1) $display("FAIL frame_cnt_one: got %0d want 1", frame_cnt); else n_pass++;
   endtask

   task automatic test_gain_math();
      beat_t b;
      bit    ok;
      write_gain(2'd0, 12'h600, 1'b0);
      write_gain(2'd1, 12'h200, 1'b0);
      write_gain(2'd2, 12'h800, 1'b0);
      n_checks++; if (pending !== 1'b1) $display("FAIL math_pending_set: got %b want 1", pending); else n_pass++;
      send(pix(2'b00, 512, 1, 1023), 1'b1, 1'b0, 4'hF, 4'hF);
      n_checks++; if (pending !== 1'b0) $display("FAIL math_pending_clear: got %b want 0", pending); else n_pass++;
      send(pix(2'b00, 100, 3, 300), 1'b0, 1'b1, 4'hF, 4'hF);
      recv(b, ok);
      n_checks++; if (!ok || b.data !== pix(2'b00, 768, 1, 1023))
         $display("FAIL gain_math_sat: ok %0d got %h want %h", ok, b.data, pix(2'b00, 768, 1, 1023)); else n_pass++;
      recv(b, ok);
      n_checks++; if (!ok || b.data !== pix(2'b00, 150, 2, 600) || b.last !== 1'b1)
         $display("FAIL gain_math_round: ok %0d got %h last %b want %h last 1", ok, b.data, b.last,
                  pix(2'b00, 150, 2, 600)); else n_pass++;
      n_checks++; if (frame_cnt !== 16'd2) $display("FAIL frame_cnt_two: got %0d want 2", frame_cnt); else n_pass++;
   endtask

   task automatic test_frame_sync();
      beat_t b;
      bit    ok;
      do_reset();
      send(pix(2'b00, 100, 200, 300), 1'b1, 1'b0, 4'hF, 4'hF);
      write_gain(2'd0, 12'h800, 1'b0);
      n_checks++; if (pending !== 1'b1) $display("FAIL sync_pending_mid: got %b want 1", pending); else n_pass++;
      send(pix(2'b00, 100, 200, 300), 1'b0, 1'b0, 4'hF, 4'hF);
      send(pix(2'b00, 5, 6, 7), 1'b0, 1'b1, 4'hF, 4'hF);
      n_checks++; if (pending !== 1'b1) $display("FAIL sync_pending_hold: got %b want 1", pending); else n_pass++;
      send(pix(2'b00, 100, 200, 300), 1'b1, 1'b0, 4'hF, 4'hF);
      n_checks++; if (pending !== 1'b0) $display("FAIL sync_pending_clear: got %b want 0", pending); else n_pass++;
      // Write to channel 1 landing on the same cycle as the SOF accept.
      gain_wr   = 1'b1;
      gain_sel  = 2'd1;
      gain_data = 12'h800;
      send(pix(2'b00, 100, 200, 300), 1'b1, 1'b0, 4'hF, 4'hF);
      gain_wr = 1'b0;
      n_checks++; if (pending !== 1'b1) $display("FAIL sync_same_cycle_pending: got %b want 1", pending); else n_pass++;
      send(pix(2'b00, 100, 200, 300), 1'b1, 1'b0, 4'hF, 4'hF);
      n_checks++; if (pending !== 1'b0) $display("FAIL sync_next_sof_clear: got %b want 0", pending); else n_pass++;
      recv(b, ok);
      n_checks++; if (!ok || b.data !== pix(2'b00, 100, 200, 300))
         $display("FAIL sync_before_write: ok %0d got %h want %h", ok, b.data, pix(2'b00, 100, 200, 300)); else n_pass++;
      recv(b, ok);
      n_checks++; if (!ok || b.data !== pix(2'b00, 100, 200, 300))
         $display("FAIL sync_mid_frame_a: ok %0d got %h want %h", ok, b.data, pix(2'b00, 100, 200, 300)); else n_pass++;
      recv(b, ok);
      n_checks++; if (!ok || b.data !== pix(2'b00, 5, 6, 7))
         $display("FAIL sync_mid_frame_b: ok %0d got %h want %h", ok, b.data, pix(2'b00, 5, 6, 7)); else n_pass++;
      recv(b, ok);
      n_checks++; if (!ok || b.data !== pix(2'b00, 200, 200, 300))
         $display("FAIL sync_sof_doubled: ok %0d got %h want %h", ok, b.data, pix(2'b00, 200, 200, 300)); else n_pass++;
      recv(b, ok);
      n_checks++; if (!ok || b.data !== pix(2'b00, 200, 200, 300))
         $display("FAIL sync_same_cycle_old: ok %0d got %h want %h", ok, b.data, pix(2'b00, 200, 200, 300)); else n_pass++;
      recv(b, ok);
      n_checks++; if (!ok || b.data !== pix(2'b00, 200, 400, 300))
         $display("FAIL sync_same_cycle_new: ok %0d got %h want %h", ok, b.data, pix(2'b00, 200, 400, 300)); else n_pass++;
      n_checks++; if (frame_cnt !== 16'd4) $display("FAIL sync_frame_cnt: got %0d want 4", frame_cnt); else n_pass++;
   endtask

   task automatic test_bypass();
      beat_t b;
      bit    ok;
      // Active gains here are {2.0, 2.0, 1.0}.
      write_gain(2'd0, 12'h000, 1'b1);
      send(pix(2'b11, 10, 20, 30), 1'b0, 1'b0, 4'hF, 4'hF);
      send(pix(2'b11, 1023, 500, 7), 1'b1, 1'b1, 4'h7, 4'h5);
      write_gain(2'd1, 12'h400, 1'b0);
      send(pix(2'b11, 1023, 500, 7), 1'b1, 1'b0, 4'hF, 4'hF);
      recv(b, ok);
      n_checks++; if (!ok || b.data !== pix(2'b00, 20, 40, 30))
         $display("FAIL bypass_not_yet: ok %0d got %h want %h", ok, b.data, pix(2'b00, 20, 40, 30)); else n_pass++;
      recv(b, ok);
      n_checks++; if (!ok || b.data !== pix(2'b00, 1023, 500, 7))
         $display("FAIL bypass_data_pad: ok %0d got %h want %h", ok, b.data, pix(2'b00, 1023, 500, 7)); else n_pass++;
      n_checks++; if (b.keep !== 4'h7 || b.strb !== 4'h5 || b.last !== 1'b1 || b.user !== 1'b1)
         $display("FAIL bypass_sideband: got keep %h strb %h last %b user %b want 7 5 1 1",
                  b.keep, b.strb, b.last, b.user); else n_pass++;
      recv(b, ok);
      n_checks++; if (!ok || b.data !== pix(2'b00, 0, 500, 7))
         $display("FAIL gain_zero: ok %0d got %h want %h", ok, b.data, pix(2'b00, 0, 500, 7)); else n_pass++;
   endtask

   task automatic test_backpressure();
      beat_t       b;
      logic [31:0] exp_q[$];
      logic [31:0] exp_d, prev_data;
      bit          done, stall_prev;
      int          cyc, n_out;
      do_reset();
      write_gain(2'd0, 12'h5A3, 1'b0);
      write_gain(2'd1, 12'h0FF, 1'b0);
      write_gain(2'd2, 12'hC00, 1'b0);
      done       = 0;
      stall_prev = 0;
      prev_data  = '0;
      cyc        = 0;
      fork
         begin
            for (int i = 0; i < 1000; i++) begin
               int c0, c1, c2;
               c0 = $urandom_range(0, 1023);
               c1 = $urandom_range(0, 1023);
               c2 = $urandom_range(0, 1023);
               send(pix(2'($urandom_range(0, 3)), c0, c1, c2), (i == 0), 1'b0, 4'hF, 4'hF);
               exp_q.push_back(pix(2'b00, model(c0, 12'h5A3), model(c1, 12'h0FF), model(c2, 12'hC00)));
            end
            done = 1;
         end
         begin
            while (!done) begin
               tick();
               cyc++;
               if (cyc >= 200 && cyc < 205) vo_ready = 1'b0;
               else vo_ready = ($urandom_range(0, 3) != 0);
            end
            vo_ready = 1'b1;
         end
         begin
            while (!done) begin
               @(negedge clk);
               if (stall_prev) begin
                  n_checks++;
                  if (vo_valid !== 1'b1 || vo_data !== prev_data)
                     $display("FAIL stall_hold: got valid %b data %h want 1 %h", vo_valid, vo_data, prev_data);
                  else n_pass++;
               end
               stall_prev = vo_valid && !vo_ready;
               prev_data  = vo_data;
            end
         end
      join
      for (int i = 0; i < 2000 && out_q.size() < 1000; i++) tick();
      repeat (10) tick();
      n_out = out_q.size();
      n_checks++; if (n_out !== 1000) $display("FAIL bp_count: got %0d beats want 1000", n_out); else n_pass++;
      for (int i = 0; i < 1000 && out_q.size() > 0; i++) begin
         b     = out_q.pop_front();
         exp_d = exp_q.pop_front();
         n_checks++;
         if (b.data !== exp_d || b.user !== (i == 0))
            $display("FAIL bp_beat_%0d: got %h user %b want %h user %b", i, b.data, b.user, exp_d, (i == 0));
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid_frame();
      beat_t b;
      bit    ok;
      write_gain(2'd0, 12'h800, 1'b0);
      send(pix(2'b00, 1, 2, 3), 1'b0, 1'b0, 4'hF, 4'hF);
      send(pix(2'b00, 4, 5, 6), 1'b0, 1'b0, 4'hF, 4'hF);
      send(pix(2'b00, 7, 8, 9), 1'b0, 1'b0, 4'hF, 4'hF);
      rst_n = 1'b0;
      out_q.delete();
      tick();
      n_checks++; if (vo_valid !== 1'b0) $display("FAIL rst_mid_tvalid: got %b want 0", vo_valid); else n_pass++;
      tick();
      rst_n = 1'b1;
      tick();
      n_checks++; if (pending !== 1'b0) $display("FAIL rst_mid_pending: got %b want 0", pending); else n_pass++;
      n_checks++; if (frame_cnt !== 16'd0) $display("FAIL rst_mid_frame_cnt: got %0d want 0", frame_cnt); else n_pass++;
      repeat (6) tick();
      n_checks++; if (out_q.size() !== 0) $display("FAIL rst_mid_flush: got %0d stray beats want 0", out_q.size()); else n_pass++;
      send(pix(2'b00, 512, 100, 1023), 1'b1, 1'b0, 4'hF, 4'hF);
      recv(b, ok);
      n_checks++; if (!ok || b.data !== pix(2'b00, 512, 100, 1023))
         $display("FAIL rst_mid_unity: ok %0d got %h want %h", ok, b.data, pix(2'b00, 512, 100, 1023)); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_gain_math();
      test_frame_sync();
      test_bypass();
      test_backpressure();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
